// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// Request-side controller for a small synchronous memory. Incoming read/write
// requests are buffered in a FIFO and issued to the memory one at a time, in
// order. Read data is returned on a valid/ready response channel; writes
// produce no response.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = FIFO not full)
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   request address / write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             captured read data, stable while rsp_valid
//   addr_in, data_in      memory address / write data (hold outside ISSUE)
//   wr_en, op_en, cs      memory strobes, high only during ISSUE
//   data_out              memory read data
//   busy                  FSM not IDLE or FIFO non-empty
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_en,
    output logic                  op_en,
    output logic                  cs,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    // FSM and command registers
    state_t                state_q, state_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Registered memory strobes and response valid
    logic                  cs_q, cs_d;
    logic                  op_en_q, op_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;

    assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    // req_ready depends on fullness only; a same-cycle pop does not free a slot.
    assign push_s       = req_valid && !fifo_full_s;
    // IDLE is the only state that consumes the FIFO head.
    assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;
    assign head_s       = fifo_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM next-state, command capture, latency count and read-data capture
    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    {cmd_write_d, cmd_addr_d, cmd_wdata_d} = head_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_write_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(RD_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    rdata_d = data_out;
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are computed from the next state so their registers are
        // high exactly while the FSM sits in ISSUE.
        cs_d        = (state_d == ST_ISSUE);
        op_en_d     = (state_d == ST_ISSUE);
        wr_en_d     = (state_d == ST_ISSUE) && cmd_write_d;
        rsp_valid_d = (state_d == ST_RESP);
    end

    // FSM, command, latency, read-data and strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= {ADDR_WIDTH{1'b0}};
            cmd_wdata_q <= {DATA_WIDTH{1'b0}};
            lat_q       <= {LAT_W{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            cs_q        <= 1'b0;
            op_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            lat_q       <= lat_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            op_en_q     <= op_en_d;
            wr_en_q     <= wr_en_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Command registers change only when a new command enters ISSUE, so the
    // memory address/data pins hold their last driven value in other states.
    assign addr_in   = cmd_addr_q;
    assign data_in   = cmd_wdata_q;
    assign cs        = cs_q;
    assign op_en     = op_en_q;
    assign wr_en     = wr_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign req_ready = !fifo_full_s;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
// Self-checking bench for mem_req_ctrl: a 16x8 memory model drives data_out,
// a reference model (request-order memory image plus queues of expected
// memory operations and read responses) checks every bus operation and every
// response. Directed timing sequences, a vector table and random traffic.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [3:0] addr_in;
    logic [7:0] data_in;
    logic       wr_en;
    logic       op_en;
    logic       cs;
    logic [7:0] data_out;
    logic       busy;

    mem_req_ctrl #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .RD_LATENCY(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .op_en    (op_en),
        .cs       (cs),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
    } op_t;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rsp    = 0;
    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];
    op_t        op_q    [$];
    logic [7:0] rsp_q   [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Memory model plus reference scoreboard, sampled on the active edge
    // (DUT state updates are non-blocking, so pre-edge values are seen).
    always @(posedge clk) begin
        if (reset) begin
            op_q.delete();
            rsp_q.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        end else begin
            if (cs) begin
                if (op_q.size() == 0) begin
                    fail_now("bus_unexpected_op");
                end else begin
                    op_t op;
                    op = op_q.pop_front();
                    chk("bus_op_en", op_en, 1);
                    chk("bus_wr_en", wr_en, op.wr);
                    chk("bus_addr", addr_in, op.a);
                    if (op.wr) chk("bus_wdata", data_in, op.d);
                end
                if (op_en && wr_en) mem[addr_in] = data_in;
                else if (op_en)     data_out <= mem[addr_in];
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                else                   chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    ref_mem[req_addr] = req_wdata;
                    op_q.push_back('{1'b1, req_addr, req_wdata});
                end else begin
                    op_q.push_back('{1'b0, req_addr, req_wdata});
                    rsp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push_req(input logic w, input logic [3:0] a, input logic [7:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("push_timeout");
        else         @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now(name);
        else         chk(name, rsp_rdata, exp);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((busy || rsp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now(name);
        chk({name, "_op_q_empty"}, op_q.size(), 0);
        chk({name, "_rsp_q_empty"}, rsp_q.size(), 0);
    endtask

    vec_t       tbl [10];
    logic [3:0] fill_addr [6];
    int         base;

    initial begin
        tbl[0] = '{1'b1, 4'h3, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'h3, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'h7, 8'h5C, 8'h00};
        tbl[3] = '{1'b0, 4'h7, 8'h00, 8'h5C};
        tbl[4] = '{1'b1, 4'h3, 8'h11, 8'h00};
        tbl[5] = '{1'b0, 4'h3, 8'hFF, 8'h11};
        tbl[6] = '{1'b0, 4'h7, 8'h00, 8'h5C};
        tbl[7] = '{1'b1, 4'hF, 8'hFF, 8'h00};
        tbl[8] = '{1'b0, 4'hF, 8'h00, 8'hFF};
        tbl[9] = '{1'b0, 4'h0, 8'h00, 8'h00};
        fill_addr = '{4'h3, 4'h7, 4'hF, 4'h0, 4'h3, 4'h7};

        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        data_out  = 8'h00;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        // Asynchronous reset between edges: outputs clear without a clock.
        #2 reset = 1'b1;
        #1;
        chk("rst_cs", cs, 0);
        chk("rst_op_en", op_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr_in", addr_in, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single write: strobes high for exactly cycle E+2.
        push_req(1'b1, 4'h3, 8'hA5);
        chk("wr_e1_cs", cs, 0);
        @(negedge clk);
        chk("wr_e2_cs", cs, 1);
        chk("wr_e2_op_en", op_en, 1);
        chk("wr_e2_wr_en", wr_en, 1);
        chk("wr_e2_addr", addr_in, 4'h3);
        chk("wr_e2_data", data_in, 8'hA5);
        @(negedge clk);
        chk("wr_e3_cs", cs, 0);
        chk("wr_e3_busy", busy, 0);
        chk("wr_e3_rsp_valid", rsp_valid, 0);
        chk("wr_e3_addr_hold", addr_in, 4'h3);

        // Write then read: response 4 cycles after read acceptance.
        push_req(1'b1, 4'h7, 8'h5C);
        repeat (2) @(negedge clk);
        push_req(1'b0, 4'h7, 8'h00);
        @(negedge clk);
        chk("rd_r2_cs", cs, 1);
        chk("rd_r2_wr_en", wr_en, 0);
        @(negedge clk);
        chk("rd_r3_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("rd_r4_rsp_valid", rsp_valid, 1);
        chk("rd_r4_rsp_rdata", rsp_rdata, 8'h5C);
        @(negedge clk);

        // Vector table, one request at a time.
        for (int i = 0; i < 10; i++) begin
            push_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].wr) drain("tbl_write_done");
            else           wait_rsp("tbl_read_data", tbl[i].exp_rdata);
            @(negedge clk);
        end

        // Fill and backpressure.
        rsp_ready = 1'b0;
        base = n_rsp;
        for (int i = 0; i < 5; i++) push_req(1'b0, fill_addr[i], 8'h00);
        chk("fill_req_ready_low", req_ready, 0);
        repeat (3) @(negedge clk);
        chk("fill_rsp_valid", rsp_valid, 1);
        chk("fill_rsp_rdata", rsp_rdata, 8'h11);
        chk("fill_req_ready_still_low", req_ready, 0);
        chk("fill_busy", busy, 1);
        rsp_ready = 1'b1;
        push_req(1'b0, fill_addr[5], 8'h00);
        drain("fill_drain");
        chk("fill_rsp_count", n_rsp - base, 6);
        chk("fill_req_ready_back", req_ready, 1);

        // Pointer wrap: alternating write/read pairs.
        base = n_rsp;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a;
            logic [7:0] d;
            a = 4'((i * 5 + 1) % 16);
            d = 8'($urandom);
            push_req(1'b1, a, d);
            push_req(1'b0, a, 8'h00);
        end
        drain("wrap_drain");
        chk("wrap_rsp_count", n_rsp - base, 10);

        // Reset during WAIT: the read is dropped, then a new read completes.
        base = n_rsp;
        push_req(1'b0, 4'h3, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_req_ready", req_ready, 1);
        chk("rstw_cs", cs, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstw_no_rsp", n_rsp - base, 0);
        chk("rstw_idle", busy, 0);
        push_req(1'b0, 4'h3, 8'h00);
        wait_rsp("rstw_after_read", 8'h11);
        @(negedge clk);

        // Random traffic with random response backpressure.
        for (int c = 0; c < 600; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        drain("rand_drain");
        chk("rand_final_req_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
